pl_seq_gen: RTL and testbench
=============================

# pl_seq_gen

Job engine on the PL side that consumes the one-cycle start pulse from the control FSM and returns its one-cycle finish pulse. On start it emits a configurable-length incrementing data stream over a valid/ready master port, accumulates a checksum of accepted words, and guards against a stalled sink with a timeout. It shares the PL clock with the control FSM, so no synchronisation is needed between them.

## Interface
- DATA_WIDTH, 32, width of stream data, seed and checksum
- LEN_WIDTH, 16, width of job length and word counter
- TIMEOUT, 1024, consecutive stalled cycles before abort; must be ≥2
- IDLE / RUN / DONE, 3'b001 / 3'b010 / 3'b100, one-hot state encodings
- pl_clk  in  1  PL clock; the only clock
- pl_rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle job request from control FSM start output
- cfg_len  in  LEN_WIDTH  job length in words, sampled on accepted start
- cfg_seed  in  DATA_WIDTH  first data word, sampled on accepted start
- m_data  out  DATA_WIDTH  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready from sink
- finish  out  1  one-cycle job-complete pulse, drives control FSM finish input
- busy  out  1  state != IDLE
- timeout_err  out  1  last job aborted by timeout
- checksum  out  DATA_WIDTH  sum of accepted words, modulo 2^DATA_WIDTH
- word_cnt  out  LEN_WIDTH  number of words accepted in current/last job
- mnt_state  out  3  current state, for monitoring

## Operation
- Reset: state=IDLE; m_valid=0, m_data=0, finish=0, busy=0, timeout_err=0, checksum=0, word_cnt=0, internal length and stall counter 0.
- IDLE: start=1 is accepted. On accept, len and data register load from cfg_len and cfg_seed; checksum, word_cnt, stall counter and timeout_err clear. If cfg_len=0, go to DONE; otherwise go to RUN.
- RUN: m_valid=1 and m_data=current data word.
- A transfer occurs on m_valid&&m_ready. On each transfer:
  - checksum += m_data, truncated to DATA_WIDTH.
  - word_cnt increments.
  - Data increments by 1, wrapping at 2^DATA_WIDTH.
  - Stall counter clears.
- The transfer that makes word_cnt equal to len moves the FSM to DONE.
- A cycle with m_valid&&!m_ready increments the stall counter. m_data must hold stable while stalled.
- Timeout: the stall counter reaching TIMEOUT-1 while still stalled sets timeout_err=1 and moves the FSM to DONE. m_valid drops and the pending word is not counted.
- DONE: finish=1 for exactly this cycle; next state is IDLE. m_valid=0.
- start in RUN or DONE is ignored. There is no queueing and the latched configuration does not change.
- checksum, word_cnt and timeout_err hold after DONE until the next accepted start.
- Unreachable state encoding returns to IDLE on the next clock with outputs deasserted.
- pl_rst asserted mid-job returns the block immediately, asynchronously, to reset values. No finish pulse is issued.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from m_ready to m_valid.
- Accepted start sampled at edge T:
  - m_valid=1 with m_data=seed from T+1.
  - With m_ready held high and len=N, words transfer in cycles T+1..T+N.
  - finish=1 in cycle T+N+1; busy=0 from T+N+2.
- len=0: finish=1 in cycle T+1 and m_valid never asserts.
- Each stalled cycle adds exactly one cycle to job latency.
- Timeout: after TIMEOUT consecutive stalled cycles, finish pulses in the following cycle with timeout_err=1.
- The earliest next accepted start is in the cycle after finish, when state is IDLE.

## Test plan
- Reset values: assert pl_rst asynchronously mid-cycle -> all outputs read their reset values immediately; mnt_state=3'b001.
- Basic job: seed=0x10, len=4, m_ready=1 -> m_data 0x10,0x11,0x12,0x13 in T+1..T+4; finish in T+5; checksum=0x46, word_cnt=4, timeout_err=0.
- Backpressure: seed=0, len=3, m_ready pattern 1,0,0,1,1 -> m_data stays 1 during the two stalls; finish in T+6; checksum=3.
- Zero length and wrap:
  - len=0 -> finish in T+1, m_valid never high, checksum=0.
  - seed=0xFFFFFFFF, len=2 -> data 0xFFFFFFFF then 0x00000000; checksum=0xFFFFFFFF.
- Timeout: TIMEOUT=8, len=5, m_ready=0 -> finish in T+9; timeout_err=1, word_cnt=0.
  - A following start clears timeout_err.
- Start while busy and reset mid-job:
  - start pulsed in RUN -> ignored; length and count are unchanged.
  - pl_rst during RUN -> m_valid=0 immediately and no finish pulse; the next job runs normally.

Source files
------------

// File: rtl/pl_seq_gen.sv
// rtl/pl_seq_gen.sv - start/finish job engine emitting an incrementing valid/ready stream
// Checksums accepted words and aborts the job after too many stalled cycles.
module pl_seq_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  pl_clk,
  input  logic                  pl_rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  finish,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic [LEN_WIDTH-1:0]  word_cnt,
  output logic [2:0]            mnt_state
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    DONE = 3'b100
  } state_t;

  localparam int SW = $clog2(TIMEOUT) + 1;

  state_t               state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [SW-1:0]        stall_cnt;

  always_ff @(posedge pl_clk or posedge pl_rst) begin
    if (pl_rst) begin
      state       <= IDLE;
      m_data      <= '0;
      len_q       <= '0;
      stall_cnt   <= '0;
      checksum    <= '0;
      word_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q       <= cfg_len;
            m_data      <= cfg_seed;
            checksum    <= '0;
            word_cnt    <= '0;
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
            state       <= (cfg_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (m_ready) begin
            checksum  <= checksum + m_data;
            word_cnt  <= word_cnt + LEN_WIDTH'(1);
            m_data    <= m_data + DATA_WIDTH'(1);
            stall_cnt <= '0;
            if (word_cnt + LEN_WIDTH'(1) == len_q)
              state <= DONE;
          end else if (stall_cnt == SW'(TIMEOUT - 1)) begin
            // Pending word is abandoned uncounted; m_valid drops with the state change.
            timeout_err <= 1'b1;
            state       <= DONE;
          end else begin
            stall_cnt <= stall_cnt + SW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from the state register, so m_ready never reaches m_valid.
  assign m_valid   = (state == RUN);
  assign finish    = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign mnt_state = state;

endmodule

// File: tb/tb_pl_seq_gen.sv
// tb/tb_pl_seq_gen.sv - table-driven directed bench for pl_seq_gen
module tb_pl_seq_gen;

  logic        pl_clk = 1'b0;
  logic        pl_rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [31:0] cfg_seed = '0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        finish;
  logic        busy;
  logic        timeout_err;
  logic [31:0] checksum;
  logic [15:0] word_cnt;
  logic [2:0]  mnt_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 pl_clk = ~pl_clk;

  pl_seq_gen #(.DATA_WIDTH(32), .LEN_WIDTH(16), .TIMEOUT(8)) dut (
    .pl_clk(pl_clk), .pl_rst(pl_rst), .start(start), .cfg_len(cfg_len),
    .cfg_seed(cfg_seed), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .finish(finish), .busy(busy), .timeout_err(timeout_err), .checksum(checksum),
    .word_cnt(word_cnt), .mnt_state(mnt_state)
  );

  // rdy bit k-1 is m_ready in cycle T+k (1 after bit 15); rs is the cycle of an ignored restart pulse.
  typedef struct {
    logic [31:0] seed;
    logic [15:0] len;
    logic [15:0] rdy;
    int          rs;
    int          fin;
    logic [31:0] cs;
    logic [15:0] cnt;
    logic        to;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v);
    logic [31:0] ed;
    bit          done;
    bit          vseen;
    @(negedge pl_clk);
    start = 1'b1; cfg_len = v.len; cfg_seed = v.seed; m_ready = 1'b0;
    @(negedge pl_clk);
    start = 1'b0; cfg_len = 16'h0009; cfg_seed = 32'hDEAD_BEEF;
    ed = v.seed; done = 1'b0; vseen = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      m_ready = (k <= 16) ? v.rdy[k-1] : 1'b1;
      start   = (k == v.rs);
      #1;
      if (m_valid) begin
        vseen = 1'b1;
        chk("m_data", m_data, ed);
        if (m_ready) ed = ed + 32'd1;
      end
      if (finish) begin
        done = 1'b1;
        chk("finish_cycle", k, v.fin);
        chk("checksum", checksum, v.cs);
        chk("word_cnt", word_cnt, v.cnt);
        chk("timeout_err", timeout_err, v.to);
      end
      @(negedge pl_clk);
    end
    start = 1'b0; m_ready = 1'b0;
    if (!done) chk("finish_seen", 0, 1);
    if (v.len == 16'd0) chk("valid_never_for_len0", vseen, 0);
    chk("busy_after_finish", busy, 0);
    chk("idle_after_finish", mnt_state, 3'b001);
    chk("finish_single_cycle", finish, 0);
  endtask

  initial begin
    vecs[0] = '{32'h10,        16'd4, 16'hFFFF, 0, 5,  32'h46,        16'd4, 1'b0};
    vecs[1] = '{32'h0,         16'd3, 16'hFFF9, 0, 6,  32'h3,         16'd3, 1'b0};
    vecs[2] = '{32'h5,         16'd0, 16'hFFFF, 0, 1,  32'h0,         16'd0, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 16'd2, 16'hFFFF, 0, 3,  32'hFFFF_FFFF, 16'd2, 1'b0};
    vecs[4] = '{32'h0,         16'd5, 16'h0000, 0, 9,  32'h0,         16'd0, 1'b1};
    vecs[5] = '{32'h7,         16'd1, 16'hFFFF, 0, 2,  32'h7,         16'd1, 1'b0};
    vecs[6] = '{32'h100,       16'd2, 16'hFF80, 0, 10, 32'h201,       16'd2, 1'b0};
    vecs[7] = '{32'h0,         16'd4, 16'hFFFF, 2, 5,  32'h6,         16'd4, 1'b0};

    repeat (2) @(negedge pl_clk);
    chk("rst_state", mnt_state, 3'b001);
    chk("rst_valid", m_valid, 0);
    chk("rst_finish", finish, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", m_data, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_timeout_err", timeout_err, 0);
    pl_rst = 1'b0;

    for (int i = 0; i < 8; i++) run_job(vecs[i]);

    // Asynchronous reset in the middle of a RUN phase.
    begin
      bit fseen;
      @(negedge pl_clk);
      start = 1'b1; cfg_len = 16'd10; cfg_seed = 32'h20; m_ready = 1'b1;
      @(negedge pl_clk);
      start = 1'b0;
      repeat (2) @(negedge pl_clk);
      chk("midjob_running", m_valid, 1);
      #2 pl_rst = 1'b1;
      #1;
      chk("async_rst_valid", m_valid, 0);
      chk("async_rst_state", mnt_state, 3'b001);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_checksum", checksum, 0);
      chk("async_rst_word_cnt", word_cnt, 0);
      chk("async_rst_data", m_data, 0);
      chk("async_rst_finish", finish, 0);
      @(negedge pl_clk);
      pl_rst = 1'b0;
      fseen = 1'b0;
      repeat (12) begin
        @(negedge pl_clk);
        if (finish) fseen = 1'b1;
      end
      chk("no_finish_after_rst", fseen, 0);
      m_ready = 1'b0;
    end

    run_job(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
